multicycle_control_unit: RTL

Moore FSM that sequences the 8-bit multicycle CPU datapath: fetch, decode, operand read, execute, writeback. Consumes the IR, DI and CZN status returned by the datapath and drives every datapath control strobe and mux select. It is the controller end of the datapath control/status interface. One instance sits beside the datapath in the CPU top level.

---
 rtl/cpu_ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_output_decode.sv | 86 ++++++++
 rtl/multicycle_control_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: state encoding,
// opcode constants, ALU op codes, accumulator-select codes and the strobe bundle.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_FETCH2  = 4'd2,
        S_LD_MEM  = 4'd3,
        S_LD_EX   = 4'd4,
        S_LD_WB   = 4'd5,
        S_ST_RD   = 4'd6,
        S_ST_EX   = 4'd7,
        S_ST_MEM  = 4'd8,
        S_ALU_RDA = 4'd9,
        S_ALU_RDB = 4'd10,
        S_ALU_EX  = 4'd11,
        S_ALU_WB  = 4'd12,
        S_JMP     = 4'd13,
        S_HALT    = 4'd14
    } stateT;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_JUMP  = 3'b010;
    localparam logic [2:0] OP_BRZ   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_SYS   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] ACC_SEL_DI = 2'b00;
    localparam logic [1:0] ACC_SEL_J  = 2'b01;
    localparam logic [1:0] ACC_SEL_I  = 2'b10;

    typedef struct packed {
        logic       pcInc;
        logic       pcLoadEn;
        logic       diLoadEn;
        logic       trWriteEn;
        logic       irWriteEn;
        logic       memoryReadEn;
        logic       memoryWriteEn;
        logic       accumulatorWriteEn;
        logic       aRegWriteEn;
        logic       bRegWriteEn;
        logic       aluResWriteEn;
        logic       ldCzn;
        logic       pcOrTr;
        logic       regOrMem;
        logic       regBOr0;
        logic       regAOr0;
        logic [1:0] selAccumulatorAddress;
        logic [1:0] aluOpControl;
        logic       halted;
    } ctrlT;

    function automatic logic [2:0] opcodeOf(input logic [7:0] ir);
        return ir[7:5];
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Pure Moore decode of the controller state into datapath strobes and selects.
// Only ALU_EX looks at the opcode, which is stable because IR loads in FETCH alone.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  stateT      state,
    input  logic [2:0] opcode,
    output ctrlT       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.pcOrTr       = 1'b1;
                ctrl.memoryReadEn = 1'b1;
                ctrl.irWriteEn    = 1'b1;
                ctrl.pcInc        = 1'b1;
            end
            S_FETCH2: begin
                ctrl.pcOrTr       = 1'b1;
                ctrl.memoryReadEn = 1'b1;
                ctrl.trWriteEn    = 1'b1;
                ctrl.diLoadEn     = 1'b1;
                ctrl.pcInc        = 1'b1;
            end
            S_LD_MEM: begin
                ctrl.memoryReadEn = 1'b1;
                ctrl.bRegWriteEn  = 1'b1;
            end
            S_LD_EX: begin
                ctrl.regAOr0       = 1'b1;
                ctrl.aluOpControl  = ALU_ADD;
                ctrl.aluResWriteEn = 1'b1;
            end
            S_LD_WB: begin
                ctrl.selAccumulatorAddress = ACC_SEL_DI;
                ctrl.accumulatorWriteEn    = 1'b1;
            end
            S_ST_RD: begin
                ctrl.selAccumulatorAddress = ACC_SEL_DI;
                ctrl.aRegWriteEn           = 1'b1;
            end
            S_ST_EX: begin
                ctrl.regBOr0       = 1'b1;
                ctrl.aluOpControl  = ALU_ADD;
                ctrl.aluResWriteEn = 1'b1;
            end
            S_ST_MEM: begin
                ctrl.memoryWriteEn = 1'b1;
            end
            S_ALU_RDA: begin
                ctrl.selAccumulatorAddress = ACC_SEL_I;
                ctrl.aRegWriteEn           = 1'b1;
            end
            S_ALU_RDB: begin
                ctrl.selAccumulatorAddress = ACC_SEL_J;
                ctrl.regOrMem              = 1'b1;
                ctrl.bRegWriteEn           = 1'b1;
            end
            S_ALU_EX: begin
                // NOT zeroes the A operand so the ALU passes ~B
                if (opcode == OP_SYS) begin
                    ctrl.aluOpControl = ALU_NOT;
                    ctrl.regAOr0      = 1'b1;
                end else begin
                    ctrl.aluOpControl = opcode[1:0];
                end
                ctrl.aluResWriteEn = 1'b1;
                ctrl.ldCzn         = 1'b1;
            end
            S_ALU_WB: begin
                ctrl.selAccumulatorAddress = ACC_SEL_I;
                ctrl.accumulatorWriteEn    = 1'b1;
            end
            S_JMP: begin
                ctrl.pcLoadEn = 1'b1;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore controller for the 8-bit multicycle CPU: state register, next-state
// logic, and reset gating of the decoded datapath controls.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter bit ENABLE_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir_to_cu,
    input  logic [4:0] di_to_cu,
    input  logic [2:0] czn_to_cu,
    output logic       pc_inc,
    output logic       pc_load_en,
    output logic       di_load_en,
    output logic       tr_write_en,
    output logic       ir_write_en,
    output logic       memory_read_en,
    output logic       memory_write_en,
    output logic       accumulator_write_en,
    output logic       a_reg_write_en,
    output logic       b_reg_write_en,
    output logic       alu_res_write_en,
    output logic       ld_czn,
    output logic       pc_or_tr,
    output logic       reg_or_mem,
    output logic       reg_b_or_0,
    output logic       reg_a_or_0,
    output logic [1:0] sel_accumulator_address,
    output logic [1:0] alu_op_control,
    output logic       halted,
    output logic [3:0] state_dbg
);

    stateT      state;
    stateT      nextState;
    logic [2:0] opcode;
    ctrlT       decoded;
    ctrlT       ctrl;
    logic       unusedInputs;

    // The register index and most IR/flag bits are consumed by the datapath, not here
    assign unusedInputs = ^{di_to_cu, ir_to_cu[3:0], czn_to_cu[2], czn_to_cu[0]};
    assign opcode       = opcodeOf(ir_to_cu);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = S_FETCH;
        case (state)
            S_FETCH:  nextState = S_DECODE;
            S_DECODE: begin
                if (opcode[2]) begin
                    if (opcode == OP_SYS && ir_to_cu[4]) begin
                        nextState = ENABLE_HALT ? S_HALT : S_FETCH;
                    end else begin
                        nextState = S_ALU_RDA;
                    end
                end else begin
                    nextState = S_FETCH2;
                end
            end
            S_FETCH2: begin
                // BRZ resolves here on the Z flag left by the last ALU instruction
                case (opcode)
                    OP_LOAD:  nextState = S_LD_MEM;
                    OP_STORE: nextState = S_ST_RD;
                    OP_JUMP:  nextState = S_JMP;
                    OP_BRZ:   nextState = czn_to_cu[1] ? S_JMP : S_FETCH;
                    default:  nextState = S_FETCH;
                endcase
            end
            S_LD_MEM:  nextState = S_LD_EX;
            S_LD_EX:   nextState = S_LD_WB;
            S_LD_WB:   nextState = S_FETCH;
            S_ST_RD:   nextState = S_ST_EX;
            S_ST_EX:   nextState = S_ST_MEM;
            S_ST_MEM:  nextState = S_FETCH;
            S_ALU_RDA: nextState = S_ALU_RDB;
            S_ALU_RDB: nextState = S_ALU_EX;
            S_ALU_EX:  nextState = S_ALU_WB;
            S_ALU_WB:  nextState = S_FETCH;
            S_JMP:     nextState = S_FETCH;
            S_HALT:    nextState = S_HALT;
            default:   nextState = S_FETCH;
        endcase
    end

    ctrl_output_decode uDecode (
        .state  (state),
        .opcode (opcode),
        .ctrl   (decoded)
    );

    // Holding reset silences the datapath even before the state register is known
    assign ctrl      = rst ? decoded : '0;
    assign state_dbg = rst ? state : 4'd0;

    assign pc_inc                  = ctrl.pcInc;
    assign pc_load_en              = ctrl.pcLoadEn;
    assign di_load_en              = ctrl.diLoadEn;
    assign tr_write_en             = ctrl.trWriteEn;
    assign ir_write_en             = ctrl.irWriteEn;
    assign memory_read_en          = ctrl.memoryReadEn;
    assign memory_write_en         = ctrl.memoryWriteEn;
    assign accumulator_write_en    = ctrl.accumulatorWriteEn;
    assign a_reg_write_en          = ctrl.aRegWriteEn;
    assign b_reg_write_en          = ctrl.bRegWriteEn;
    assign alu_res_write_en        = ctrl.aluResWriteEn;
    assign ld_czn                  = ctrl.ldCzn;
    assign pc_or_tr                = ctrl.pcOrTr;
    assign reg_or_mem              = ctrl.regOrMem;
    assign reg_b_or_0              = ctrl.regBOr0;
    assign reg_a_or_0              = ctrl.regAOr0;
    assign sel_accumulator_address = ctrl.selAccumulatorAddress;
    assign alu_op_control          = ctrl.aluOpControl;
    assign halted                  = ctrl.halted;

endmodule
